// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: CPU load/store data-memory controller over an inferred RAM.
// Supports RV32 byte/half/word stores with byte-lane masking and sign/zero
// extending loads. Misaligned and illegal-width accesses are flagged as faults.
// An optional clear engine zeroes the RAM after reset.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    controller can accept (transfer on valid && ready)
//   req_we_i       1 = store, 0 = load
//   req_funct3_i   RV32 width code (b, h, w, bu, hu)
//   req_addr_i     byte address, ADDR_W+2 bits
//   req_wdata_i    right-aligned store data
//   rsp_valid_o    one-cycle response pulse, one cycle after acceptance
//   rsp_rdata_o    extended load data; 0 for stores and faults
//   rsp_fault_o    misaligned or illegal funct3, valid with rsp_valid_o
//   init_busy_o    clear engine active
module data_mem_ctrl #(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W+1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_fault_o,
    output logic              init_busy_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;
    logic                ready_q;
    logic [31:0]         mem_q [DEPTH];

    // Load-side pipeline: captured with the RAM read at acceptance.
    logic                p_valid_q;
    logic                p_load_q;
    logic                p_fault_q;
    logic [1:0]          p_off_q;
    logic [2:0]          p_f3_q;
    logic [31:0]         rd_raw_q;

    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_fault_q;

    logic                acc_s;
    logic                fault_s;
    logic [3:0]          be_s;
    logic [31:0]         lane_data_s;
    logic                st_we_s;
    logic                clr_we_s;
    logic [ADDR_W-1:0]   idx_s;
    logic [1:0]          off_s;

    // Extend the addressed byte/half of a read word according to funct3.
    function automatic logic [31:0] load_ext(input logic [31:0] raw,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b010:  load_ext = raw;
            3'b100:  load_ext = {24'h000000, sh[7:0]};
            3'b101:  load_ext = {16'h0000, sh[15:0]};
            default: load_ext = 32'h0000_0000;
        endcase
    endfunction

    assign idx_s = req_addr_i[ADDR_W+1:2];
    assign off_s = req_addr_i[1:0];

    // The registered ready is masked by rst so nothing transfers in a reset cycle.
    assign req_ready_o = ready_q & ~rst_i;
    assign acc_s       = req_valid_i & req_ready_o;
    assign clr_we_s    = ~rst_i & (state_q == S_CLEAR);

    // Fault detection, byte-enable and lane-replicated store data decode.
    always_comb begin
        fault_s     = 1'b0;
        be_s        = 4'b0000;
        lane_data_s = req_wdata_i;
        case (req_funct3_i)
            3'b000: begin
                be_s        = 4'b0001 << off_s;
                lane_data_s = {4{req_wdata_i[7:0]}};
            end
            3'b001: begin
                fault_s     = off_s[0];
                be_s        = 4'b0011 << off_s;
                lane_data_s = {2{req_wdata_i[15:0]}};
            end
            3'b010: begin
                fault_s = (off_s != 2'b00);
                be_s    = 4'b1111;
            end
            3'b100: begin
                fault_s = req_we_i;   // unsigned widths are load-only
            end
            3'b101: begin
                fault_s = req_we_i | off_s[0];
            end
            default: begin
                fault_s = 1'b1;
            end
        endcase
    end

    assign st_we_s = acc_s & req_we_i & ~fault_s;

    // Control FSM: clear sweep after reset, then continuous acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            cnt_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Single-port RAM: clear write, masked store write, synchronous read.
    always_ff @(posedge clk_i) begin
        if (clr_we_s) begin
            mem_q[cnt_q] <= 32'h0000_0000;
        end else if (st_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= lane_data_s[8*b +: 8];
                end
            end
        end
        if (acc_s) begin
            rd_raw_q <= mem_q[idx_s];
        end
    end

    // Response pipeline: request attributes, then extended registered response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_valid_q   <= 1'b0;
            p_load_q    <= 1'b0;
            p_fault_q   <= 1'b0;
            p_off_q     <= 2'b00;
            p_f3_q      <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_fault_q <= 1'b0;
        end else begin
            p_valid_q   <= acc_s;
            p_load_q    <= acc_s & ~req_we_i & ~fault_s;
            p_fault_q   <= acc_s & fault_s;
            p_off_q     <= off_s;
            p_f3_q      <= req_funct3_i;
            rsp_valid_q <= p_valid_q;
            rsp_fault_q <= p_fault_q;
            rsp_rdata_q <= p_load_q ? load_ext(rd_raw_q, p_off_q, p_f3_q) : 32'h0000_0000;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_fault_o = rsp_fault_q;
    assign init_busy_o = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl with ADDR_W=4 and CLEAR_ON_RESET=1.
module tb_data_mem_ctrl;
    localparam int ADDR_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic [ADDR_W+1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_fault_o;
    logic              init_busy_o;

    int n_pass  = 0;
    int n_total = 0;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_fault_o  (rsp_fault_o),
        .init_busy_o  (init_busy_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after the final reset edge: 16 busy cycles, then ready.
    task automatic wait_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, " busy"}, {31'd0, init_busy_o}, 32'd1);
            check({tag, " ready"}, {31'd0, req_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        check({tag, " ready after clear"}, {31'd0, req_ready_o}, 32'd1);
        check({tag, " busy after clear"}, {31'd0, init_busy_o}, 32'd0);
    endtask

    // One isolated request; checks the response one cycle after acceptance.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [ADDR_W+1:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check({tag, " no early rsp"}, {31'd0, rsp_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        check({tag, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        check({tag, " rdata"}, rsp_rdata_o, exp_rd);
        check({tag, " fault"}, {31'd0, rsp_fault_o}, {31'd0, exp_f});
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = '0;
        req_wdata_i  = 32'h0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("reset rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("reset rsp_rdata", rsp_rdata_o, 32'h0);
        check("reset rsp_fault", {31'd0, rsp_fault_o}, 32'd0);
        wait_clear("clear1");

        // Every word reads zero after the sweep.
        for (int w = 0; w < 16; w++) begin
            do_req($sformatf("lw zero %0d", w), 1'b0, 3'b010, 6'(w * 4), 32'h0, 32'h0, 1'b0);
        end

        // Back-to-back sw then lw to the same word.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 6'h08; req_wdata_i = 32'hDEADBEEF;
        @(posedge clk_i); #1;
        req_we_i = 1'b0; req_wdata_i = 32'h0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("b2b sw rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("b2b sw rdata", rsp_rdata_o, 32'h0);
        @(posedge clk_i); #1;
        check("b2b lw rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("b2b lw rdata", rsp_rdata_o, 32'hDEADBEEF);
        @(posedge clk_i); #1;
        check("b2b rsp pulse ends", {31'd0, rsp_valid_o}, 32'd0);

        // Byte store over a word and extending loads.
        do_req("sw 0x10", 1'b1, 3'b010, 6'h10, 32'h11223344, 32'h0, 1'b0);
        do_req("sb 0x13", 1'b1, 3'b000, 6'h13, 32'h00000080, 32'h0, 1'b0);
        do_req("lb 0x13", 1'b0, 3'b000, 6'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("lbu 0x13", 1'b0, 3'b100, 6'h13, 32'h0, 32'h00000080, 1'b0);
        do_req("lw 0x10", 1'b0, 3'b010, 6'h10, 32'h0, 32'h80223344, 1'b0);
        do_req("lb 0x11", 1'b0, 3'b000, 6'h11, 32'h0, 32'h00000033, 1'b0);

        // Half stores: misaligned one faults without writing, aligned one merges.
        do_req("sw 0x20", 1'b1, 3'b010, 6'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req("sh 0x21 fault", 1'b1, 3'b001, 6'h21, 32'h0000BEEF, 32'h0, 1'b1);
        do_req("lw 0x20 unchanged", 1'b0, 3'b010, 6'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        do_req("sh 0x22", 1'b1, 3'b001, 6'h22, 32'h1234BEEF, 32'h0, 1'b0);
        do_req("lw 0x20 merged", 1'b0, 3'b010, 6'h20, 32'h0, 32'hBEEFF00D, 1'b0);
        do_req("lh 0x22", 1'b0, 3'b001, 6'h22, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("lhu 0x22", 1'b0, 3'b101, 6'h22, 32'h0, 32'h0000BEEF, 1'b0);
        do_req("lh 0x23 fault", 1'b0, 3'b001, 6'h23, 32'h0, 32'h0, 1'b1);

        // Other fault cases.
        do_req("lw 0x06 fault", 1'b0, 3'b010, 6'h06, 32'h0, 32'h0, 1'b1);
        do_req("f3=011 fault", 1'b0, 3'b011, 6'h08, 32'h0, 32'h0, 1'b1);
        do_req("f3=111 fault", 1'b0, 3'b111, 6'h08, 32'h0, 32'h0, 1'b1);
        do_req("sb f3=100 fault", 1'b1, 3'b100, 6'h24, 32'h000000AA, 32'h0, 1'b1);
        do_req("lw 0x24 no write", 1'b0, 3'b010, 6'h24, 32'h0, 32'h0, 1'b0);

        // Highest word.
        do_req("sw top", 1'b1, 3'b010, 6'h3C, 32'hA5A55A5A, 32'h0, 1'b0);
        do_req("lw top", 1'b0, 3'b010, 6'h3C, 32'h0, 32'hA5A55A5A, 1'b0);
        do_req("lbu top+3", 1'b0, 3'b100, 6'h3F, 32'h0, 32'h000000A5, 1'b0);

        // Reset with a load in flight: the response is dropped.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 6'h08;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("ready low in reset", {31'd0, req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("inflight dropped", {31'd0, rsp_valid_o}, 32'd0);
        check("inflight rdata", rsp_rdata_o, 32'h0);

        // Reset again at clear cycle 7; sweep restarts from word 0.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_i); #1;
        end
        check("mid-clear busy", {31'd0, init_busy_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("mid-clear rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        wait_clear("clear2");

        do_req("lw 0x08 cleared", 1'b0, 3'b010, 6'h08, 32'h0, 32'h0, 1'b0);
        do_req("lw 0x10 cleared", 1'b0, 3'b010, 6'h10, 32'h0, 32'h0, 1'b0);
        do_req("lw top cleared", 1'b0, 3'b010, 6'h3C, 32'h0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data-memory controller for the CPU load/store path. It succeeds the bare 32-bit block-RAM data memory.
- Adds RV32 byte/half/word stores with byte-lane masking, and sign/zero-extending loads.
- Detects misaligned and illegal-width accesses.
- Has a valid/ready request interface with one-cycle response latency.
- Optionally sweeps the RAM to zero after reset.
- Sits between the core's MEM stage and an internal inferred RAM.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W 32-bit words; byte address is ADDR_W+2 bits.
- CLEAR_ON_RESET, 1, when 1 a clear engine zeroes every word after reset before accepting requests; when 0 there is no clear and RAM contents are undefined.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; a transfer occurs when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-aligned (low bits used for b/h)
- rsp_valid  out  1  one-cycle pulse, response for the request accepted the previous cycle
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  valid with rsp_valid: misaligned or illegal funct3
- init_busy  out  1  clear engine active

Behaviour:
- Reset, while rst=1 on a clock edge:
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - Any in-flight response is dropped.
  - Clear counter set to 0.
  - init_busy=1 if CLEAR_ON_RESET, else 0.
  - req_ready=0 throughout the reset cycle.
- States: CLEAR, RUN.
  - After reset, state is CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR:
  - Writes 0 to word[cnt] each cycle; cnt increments.
  - When the write to word DEPTH-1 completes, go to RUN and drop init_busy. This takes exactly DEPTH cycles after reset deasserts.
  - req_ready=0 throughout.
  - rst mid-clear restarts from word 0.
- RUN:
  - req_ready=1 continuously; back-to-back requests are accepted every cycle.
- Word index = req_addr[ADDR_W+1:2]; byte offset = req_addr[1:0].
- Fault rules:
  - funct3 in {011, 110, 111} is illegal.
  - For stores, 100 and 101 are also illegal.
  - h/hu with addr[0]=1 is misaligned.
  - w with addr[1:0]!=0 is misaligned.
  - A faulting store does not write memory.
- Store, on the acceptance edge:
  - sb: write byte lane offset with wdata[7:0].
  - sh: write lanes {offset+1, offset} with wdata[15:0].
  - sw: write all 4 lanes.
  - Unselected lanes keep their old value.
- Load:
  - RAM is read synchronously in the acceptance cycle.
  - The extension unit uses the offset and funct3 registered alongside the read.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw is passthrough.
- Response timing:
  - Request accepted at edge N ⇒ rsp_valid=1 for exactly one cycle after edge N+1.
  - rsp_fault and rsp_rdata are valid in that same cycle.
  - There is no backpressure on the response; the consumer must take it.
- Ordering and hazards:
  - A load accepted the cycle after a store to the same word returns post-store data.
  - Single port, one access per cycle, so there is no read/write collision.
- Address wrap:
  - Address width equals the full byte space; no out-of-range case exists.
  - The highest word (DEPTH-1) is fully usable.

Test Plan:
- Reset then idle, CLEAR_ON_RESET=1, ADDR_W=4 → init_busy=1 and req_ready=0 for 16 cycles, then req_ready=1. A lw from every word returns 0, rsp_fault=0.
- sw 0xDEADBEEF @0x8 then lw @0x8 back-to-back → second response rdata=0xDEADBEEF, responses on consecutive cycles.
- sw 0x11223344 @0x10, then sb 0x80 @0x13:
  - lb @0x13 → 0xFFFFFF80
  - lbu @0x13 → 0x00000080
  - lw @0x10 → 0x80223344
- sh 0xBEEF @0x21 → rsp_fault=1 and memory unchanged. A following lw @0x20 returns the prior value.
- lw @0x06 → fault. funct3=011 → fault, rdata=0. sb with funct3=100 → fault, no write.
- Assert rst for 1 cycle mid-clear (cycle 7):
  - rsp_valid stays 0.
  - Clear restarts; init_busy lasts 16 cycles after rst drops.
  - Words written before the reset read 0 afterwards.
